// File: rtl/vm_pkg.sv
// Shared types, default widths and bus-slicing helper for the vending credit engine.
// Latency: none (declarations only); backpressure: not applicable.
package vm_pkg;

    typedef enum logic {
        VM_IDLE   = 1'b0,
        VM_RETURN = 1'b1
    } vm_state_t;

    localparam int VM_NUM_COINS   = 3;
    localparam int VM_NUM_ITEMS   = 4;
    localparam int VM_TOTAL_BITS  = 16;
    localparam int VM_PRICE_BITS  = 16;
    localparam int VM_WAIT_CYCLES = 100;
    localparam int VM_STOCK_BITS  = 4;

    // Flattened price/coin buses up to 1024 bits, slices up to 32 bits.
    localparam int VM_BUS_MAX   = 1024;
    localparam int VM_SLICE_MAX = 32;

    function automatic logic [VM_SLICE_MAX-1:0] vm_slice(
        input logic [VM_BUS_MAX-1:0] bus,
        input int                    idx,
        input int                    bits
    );
        logic [VM_BUS_MAX-1:0] shifted;
        logic [VM_BUS_MAX-1:0] mask;
        shifted = bus >> (idx * bits);
        mask    = ~({VM_BUS_MAX{1'b1}} << bits);
        return VM_SLICE_MAX'(shifted & mask);
    endfunction

endpackage

// File: rtl/vm_change_picker.sv
// Greedy change selector: highest-index nonzero coin value that fits in the credit.
// Latency: combinational; backpressure: none.
module vm_change_picker
    import vm_pkg::*;
#(
    parameter int NUM_COINS = VM_NUM_COINS,
    parameter int VAL_BITS  = VM_TOTAL_BITS + 1
) (
    input  logic [VAL_BITS-1:0]           credit,
    input  logic [NUM_COINS*VAL_BITS-1:0] values,
    output logic [NUM_COINS-1:0]          coin,
    output logic                          valid
);

    always_comb begin
        coin  = '0;
        valid = 1'b0;
        // Ascending scan; the last fitting coin (highest index) wins.
        for (int j = 0; j < NUM_COINS; j++) begin
            if ((values[j*VAL_BITS +: VAL_BITS] != '0) &&
                (values[j*VAL_BITS +: VAL_BITS] <= credit)) begin
                coin    = '0;
                coin[j] = 1'b1;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vending_credit_engine.sv
// Credit/dispense/change engine; stock tracking enabled by macro VM_STOCK_TRACK_EN.
// Latency: dispense/payout pulses combinational, credit and reject registered; no backpressure.
module vending_credit_engine
    import vm_pkg::*;
#(
    parameter int NUM_COINS   = VM_NUM_COINS,
    parameter int NUM_ITEMS   = VM_NUM_ITEMS,
    parameter int TOTAL_BITS  = VM_TOTAL_BITS,
    parameter int PRICE_BITS  = VM_PRICE_BITS,
    parameter int WAIT_CYCLES = VM_WAIT_CYCLES,
    parameter int STOCK_BITS  = VM_STOCK_BITS
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_COINS-1:0]            i_input_coin,
    input  logic [NUM_ITEMS-1:0]            i_select_item,
    input  logic                            i_trigger_return,
    input  logic [NUM_COINS*PRICE_BITS-1:0] i_coin_value,
    input  logic [NUM_ITEMS*PRICE_BITS-1:0] i_item_price,
    input  logic                            i_refill,
    output logic [NUM_ITEMS-1:0]            o_available_item,
    output logic [NUM_ITEMS-1:0]            o_output_item,
    output logic [NUM_COINS-1:0]            o_return_coin,
    output logic                            o_accept_coin,
    output logic                            o_coin_reject,
    output logic [TOTAL_BITS-1:0]           o_current_total
);

    // Arithmetic width wide enough that credit - price + coin never wraps.
    localparam int CW = ((TOTAL_BITS > PRICE_BITS) ? TOTAL_BITS : PRICE_BITS) + 1;
    localparam int TW = $clog2(WAIT_CYCLES + 2);
    localparam logic [CW-1:0] CREDIT_MAX = CW'({TOTAL_BITS{1'b1}});
    localparam logic [TW-1:0] WAIT_LOAD  = TW'(WAIT_CYCLES);

    vm_state_t               state, state_nxt;
    logic [TOTAL_BITS-1:0]   credit, credit_nxt;
    logic [TW-1:0]           timer, timer_nxt;
    logic                    coin_reject, coin_reject_nxt;

    logic [CW-1:0]           price [NUM_ITEMS];
    logic [CW-1:0]           value [NUM_COINS];
    logic [NUM_COINS*CW-1:0] values_flat;
    logic [CW-1:0]           credit_w, disp_price, coin_val, pay_val, sum;
    logic [NUM_ITEMS-1:0]    in_stock, available, dispense;
    logic [NUM_COINS-1:0]    pay_coin;
    logic                    pay_vld, coin_in, coin_ok, go_return;

    assign credit_w = CW'(credit);

    always_comb begin
        values_flat = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            price[i] = CW'(PRICE_BITS'(vm_slice(VM_BUS_MAX'(i_item_price), i, PRICE_BITS)));
        end
        for (int j = 0; j < NUM_COINS; j++) begin
            value[j] = CW'(PRICE_BITS'(vm_slice(VM_BUS_MAX'(i_coin_value), j, PRICE_BITS)));
            values_flat[j*CW +: CW] = value[j];
        end
    end

`ifdef VM_STOCK_TRACK_EN
    logic [STOCK_BITS-1:0] stock [NUM_ITEMS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= '1;
        end else if (i_refill) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= '1;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (dispense[i]) stock[i] <= stock[i] - STOCK_BITS'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) in_stock[i] = (stock[i] != '0);
    end
`else
    logic unused_refill;
    assign unused_refill = i_refill;
    assign in_stock      = '1;
`endif

    // Gated by reset_n so every output reads 0 while reset is held.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            available[i] = reset_n && (credit_w >= price[i]) && in_stock[i];
        end
    end

    always_comb begin
        dispense   = '0;
        disp_price = '0;
        coin_in    = |i_input_coin;
        coin_val   = '0;
        pay_val    = '0;
        if (state == VM_IDLE) begin
            for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
                if (i_select_item[i] && available[i]) begin
                    dispense    = '0;
                    dispense[i] = 1'b1;
                    disp_price  = price[i];
                end
            end
        end
        for (int j = NUM_COINS - 1; j >= 0; j--) begin
            if (i_input_coin[j]) coin_val = value[j];
        end
        for (int j = 0; j < NUM_COINS; j++) begin
            if (pay_coin[j]) pay_val = value[j];
        end
    end

    vm_change_picker #(
        .NUM_COINS (NUM_COINS),
        .VAL_BITS  (CW)
    ) u_picker (
        .credit (credit_w),
        .values (values_flat),
        .coin   (pay_coin),
        .valid  (pay_vld)
    );

    always_comb begin
        state_nxt       = state;
        credit_nxt      = credit;
        timer_nxt       = timer;
        coin_reject_nxt = 1'b0;
        go_return       = 1'b0;
        coin_ok         = 1'b0;
        sum             = '0;
        case (state)
            VM_IDLE: begin
                go_return       = (credit != '0) && (i_trigger_return || (timer == '0));
                sum             = credit_w - disp_price + coin_val;
                // A pending return wins over a same-cycle coin.
                coin_ok         = coin_in && !go_return && (sum <= CREDIT_MAX);
                coin_reject_nxt = coin_in && !coin_ok;
                credit_nxt      = TOTAL_BITS'(coin_ok ? sum : (credit_w - disp_price));
                if (coin_ok || (|dispense)) begin
                    timer_nxt = WAIT_LOAD;
                end else if (timer != '0) begin
                    timer_nxt = timer - TW'(1);
                end
                if (go_return) state_nxt = VM_RETURN;
            end
            VM_RETURN: begin
                if (pay_vld) credit_nxt = TOTAL_BITS'(credit_w - pay_val);
                if (!pay_vld || (credit_w == pay_val)) begin
                    state_nxt = VM_IDLE;
                    timer_nxt = WAIT_LOAD;
                end
            end
            default: state_nxt = VM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= VM_IDLE;
            credit      <= '0;
            timer       <= WAIT_LOAD;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            timer       <= timer_nxt;
            coin_reject <= coin_reject_nxt;
        end
    end

    assign o_available_item = available;
    assign o_output_item    = dispense;
    assign o_return_coin    = (state == VM_RETURN) ? pay_coin : '0;
    assign o_accept_coin    = reset_n && (state == VM_IDLE);
    assign o_coin_reject    = coin_reject;
    assign o_current_total  = credit;

endmodule
